// File: rtl/student_fir_sample_ctrl.sv
// Sample-history controller: writes each accepted sample into a circular RAM and
// replays the newest NumTaps samples (newest first). Optional macro FIR_SAMPLE_CLEAR_EN.
module student_fir_sample_ctrl #(
  parameter int AddrWidth = 2,
  parameter int DataSize  = 16,
  parameter int NumTaps   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataSize-1:0]  sample_i,
  input  logic                 sample_valid_i,
  output logic                 sample_ready_o,
  output logic                 ena_o,
  output logic                 wea_o,
  output logic [AddrWidth-1:0] addra_o,
  output logic [DataSize-1:0]  dia_o,
  output logic                 enb_o,
  output logic [AddrWidth-1:0] addrb_o,
  input  logic [DataSize-1:0]  dob_i,
  output logic [DataSize-1:0]  tap_sample_o,
  output logic [AddrWidth-1:0] tap_idx_o,
  output logic                 tap_valid_o,
  output logic                 tap_last_o
);

  localparam logic [AddrWidth-1:0] LastTap = AddrWidth'(NumTaps - 1);

`ifdef FIR_SAMPLE_CLEAR_EN
  localparam logic [AddrWidth-1:0] LastAddr = '1;
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, CLEAR} state_e;
`else
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;
`endif

  state_e                 state_q;
  logic [AddrWidth-1:0]   wr_ptr_q, rd_cnt_q;
  logic                   ready_q, ena_q, wea_q, enb_q;
  logic [AddrWidth-1:0]   addra_q, addrb_q, tap_idx_q;
  logic [DataSize-1:0]    dia_q;
  logic                   tap_valid_q, tap_last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      enb_q       <= 1'b0;
      addrb_q     <= '0;
      addra_q     <= '0;
      dia_q       <= '0;
      tap_valid_q <= 1'b0;
      tap_idx_q   <= '0;
      tap_last_q  <= 1'b0;
`ifdef FIR_SAMPLE_CLEAR_EN
      // Clear starts writing address 0 in the very first cycle after reset.
      state_q     <= CLEAR;
      ready_q     <= 1'b0;
      ena_q       <= 1'b1;
      wea_q       <= 1'b1;
`else
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      ena_q       <= 1'b0;
      wea_q       <= 1'b0;
`endif
    end else begin
      ena_q       <= 1'b0;
      wea_q       <= 1'b0;
      enb_q       <= 1'b0;
      addra_q     <= '0;
      addrb_q     <= '0;
      dia_q       <= '0;
      // RAM read data lands one cycle after the read, so tap tags trail by one.
      tap_valid_q <= (state_q == READ);
      tap_idx_q   <= (state_q == READ) ? rd_cnt_q : '0;
      tap_last_q  <= (state_q == READ) && (rd_cnt_q == LastTap);
      case (state_q)
        IDLE: if (sample_valid_i) begin
          state_q <= WRITE;
          ready_q <= 1'b0;
          ena_q   <= 1'b1;
          wea_q   <= 1'b1;
          addra_q <= wr_ptr_q;
          dia_q   <= sample_i;
        end
        WRITE: begin
          state_q  <= READ;
          rd_cnt_q <= '0;
          enb_q    <= 1'b1;
          addrb_q  <= wr_ptr_q;
        end
        READ: if (rd_cnt_q == LastTap) begin
          state_q  <= DRAIN;
          rd_cnt_q <= '0;
        end else begin
          rd_cnt_q <= rd_cnt_q + 1'b1;
          enb_q    <= 1'b1;
          addrb_q  <= addrb_q - 1'b1;
        end
        DRAIN: begin
          state_q  <= IDLE;
          wr_ptr_q <= wr_ptr_q + 1'b1;
          ready_q  <= 1'b1;
        end
`ifdef FIR_SAMPLE_CLEAR_EN
        CLEAR: if (addra_q == LastAddr) begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end else begin
          ena_q   <= 1'b1;
          wea_q   <= 1'b1;
          addra_q <= addra_q + 1'b1;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_ready_o = ready_q & ~rst_i;
  assign ena_o          = ena_q;
  assign wea_o          = wea_q;
  assign addra_o        = addra_q;
  assign dia_o          = dia_q;
  assign enb_o          = enb_q;
  assign addrb_o        = addrb_q;
  assign tap_sample_o   = tap_valid_q ? dob_i : '0;
  assign tap_idx_o      = tap_idx_q;
  assign tap_valid_o    = tap_valid_q;
  assign tap_last_o     = tap_last_q;

endmodule
